// File: rtl/dmux8way16_stream.sv
// dmux8way16_stream: steers each 16-bit input word into one of eight
// per-channel FIFOs chosen by in_sel. Each FIFO drains on its own
// valid/ready port. A full channel stalls only words addressed to it.
module dmux8way16_stream #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_data,
  input  logic [2:0]            in_sel,
  output logic [7:0]            out_valid,
  input  logic [7:0]            out_ready,
  output logic [127:0]          out_data,
  output logic [8*(AW+1)-1:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0] full;

  // Acceptance depends only on the addressed channel's registered occupancy.
  assign in_ready = ~full[in_sel];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      logic [15:0]   mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [AW-1:0] rd_ptr_inc;
      logic [AW:0]   count_reg;
      logic [15:0]   head_reg;
      logic          push;
      logic          pop;
      logic          last_word;

      assign push       = in_valid & ~full[gi] & (in_sel == 3'(gi));
      assign pop        = (count_reg != '0) & out_ready[gi];
      assign rd_ptr_inc = rd_ptr_reg + AW'(1);
      // After this cycle's pop (if any) the FIFO holds no older word, so
      // the head comes straight from a push or keeps its last value.
      assign last_word  = (count_reg == '0) | ((count_reg == (AW+1)'(1)) & pop);

      assign full[gi]                    = (count_reg == DEPTH_C);
      assign out_valid[gi]               = (count_reg != '0);
      assign out_data[gi*16 +: 16]       = head_reg;
      assign count[gi*(AW+1) +: (AW+1)]  = count_reg;

      // Storage array: write-only on push, no reset needed for contents.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg] <= in_data;
        end
      end

      // Pointer and occupancy bookkeeping.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_inc;
          count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
        end
      end

      // Registered head word; holds its value when the channel drains.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          head_reg <= '0;
        end else if (last_word) begin
          if (push) head_reg <= in_data;
        end else if (pop) begin
          head_reg <= mem[rd_ptr_inc];
        end
      end

      // Occupancy must never exceed the FIFO depth.
      a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        count_reg <= DEPTH_C);
    end
  endgenerate

  // The select must be known whenever a word is offered.
  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !$isunknown(in_sel));

endmodule
